clk_div_monitor: RTL and testbench
==================================

Name: clk_div_monitor

Overview:
- Sits directly downstream of the divide-by-5 clock generator.
- Consumes its divided-clock output as a plain data signal sampled in the clk_in domain.
- Produces a one-cycle tick per divided-clock rising edge.
- Measures period and high time in clk_in cycles, checks them against expectation, and reports lock, error and stall status for bring-up and self-check.

Parameters:
- EXP_PERIOD, 5, expected rising-to-rising distance in clk_in cycles
- LOCK_N, 4, consecutive correct periods required to assert lock
- TIMEOUT, 64, clk_in cycles without a rise before stall is declared (must be > EXP_PERIOD)
- CNT_W, 8, width of period/high-time counters (2^CNT_W > TIMEOUT)

Ports:
- clk_in, input, 1, system clock; all logic on posedge
- rst, input, 1, synchronous reset, active-low
- div_in, input, 1, divided clock from the upstream divider (same clock domain; no synchronizer)
- enable, input, 1, 1 = monitor active; 0 = measurement state cleared
- err_clr, input, 1, one-cycle pulse clears the sticky error flags
- tick, output, 1, one-cycle pulse per detected rise of div_in
- meas_valid, output, 1, one-cycle pulse when period/high_time are updated
- period, output, CNT_W, last measured period
- high_time, output, CNT_W, div_in-high samples within the last period
- lock, output, 1, LOCK_N consecutive periods equal EXP_PERIOD
- period_err, output, 1, sticky: a measured period differed from EXP_PERIOD
- stall, output, 1, sticky: TIMEOUT reached with no rise
- edge_count, output, 16, saturating count of rises while enabled

Behaviour:
- Reset: rst sampled 0 at a posedge forces all outputs, counters, div_q and the FSM to 0/IDLE at that edge. Reset mid-operation behaves the same way; no partial state survives.
- Edge detect:
  - div_q <= div_in every cycle.
  - A rise is detected at edge k when div_in==1 and div_q==0.
  - tick is registered: high for exactly the cycle following edge k.
  - edge_count increments at edge k and holds at 0xFFFF.
- cnt:
  - Loads 1 on a rise; otherwise increments.
  - Saturates at TIMEOUT.
- hcnt:
  - Loads 1 on a rise.
  - Otherwise increments when div_in==1.
- FSM states: IDLE, ARMED, TRACK, LOCKED.
  - IDLE: wait for first rise -> ARMED. No measurement is made on the first rise.
  - ARMED/TRACK/LOCKED, on a rise:
    - period <= cnt, high_time <= hcnt, meas_valid pulses the next cycle, both registered with tick.
    - If cnt==EXP_PERIOD: good <= good+1; on reaching LOCK_N -> LOCKED, lock=1.
    - Else: period_err <= 1, good <= 0, lock <= 0, -> TRACK.
  - ARMED moves to TRACK after its first measurement.
  - Any non-IDLE state, cnt reaches TIMEOUT with no rise: stall <= 1, lock <= 0, good <= 0 -> IDLE. period and high_time hold.
- enable==0:
  - FSM -> IDLE; cnt, hcnt and good cleared; lock <= 0.
  - tick, meas_valid and edge_count suppressed.
  - period_err, stall, period and high_time hold.
  - div_q still tracks div_in, so re-enabling on a high level does not create a false rise.
- err_clr:
  - Clears period_err and stall at the next edge.
  - If a new error is detected in the same cycle, the error wins (flag stays/goes 1).
- Widths: all comparisons are unsigned at CNT_W; good counter width is clog2(LOCK_N+1).

Test Plan:
- Reset, drive div_in from the divide-by-5 (period 5, high 3 low 2) -> tick every 5 cycles, first meas_valid on the 2nd rise with period=5, high_time=3; lock=1 after the 5th rise; period_err=0.
- While locked, stretch one period to 6 -> that meas_valid shows period=6, period_err=1, lock=0 the same cycle; lock re-asserts after 4 further 5-cycle periods; period_err stays 1.
- Hold div_in low 64 cycles while locked -> stall=1, lock=0, FSM in IDLE; resumed clock relocks after 5 rises; stall stays 1 until err_clr.
- Pulse err_clr in the same cycle as a period-4 rise -> period_err remains 1; err_clr in a quiet cycle -> period_err=0 next cycle.
- Pull rst low for one posedge mid-lock -> next cycle: tick, meas_valid, period, high_time, lock, errors, edge_count all 0; relock needs 5 fresh rises.
- Drop enable with div_in high for 10 cycles, re-enable -> no tick on re-enable, edge_count unchanged, first new rise only arms (no meas_valid).

Source files
------------

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: watches the divided clock from the divide-by-5 generator
// as ordinary data in the clk_in domain. It emits a tick per rising edge,
// measures period and high time, and reports lock, period error and stall.
//
// Handshake: there is no backpressure. tick and meas_valid are single-cycle
// qualifiers that are valid for exactly the cycle after the detecting edge.
// period and high_time are stable from that cycle until the next meas_valid.
module clk_div_monitor #(
    parameter int EXP_PERIOD = 5,
    parameter int LOCK_N     = 4,
    parameter int TIMEOUT    = 64,
    parameter int CNT_W      = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_in,
    input  logic             enable,
    input  logic             err_clr,
    output logic             tick,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             lock,
    output logic             period_err,
    output logic             stall,
    output logic [15:0]      edge_count,
    output logic [1:0]       dbg_state
);

    localparam int GOOD_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0]  C_EXP    = CNT_W'(EXP_PERIOD);
    localparam logic [CNT_W-1:0]  C_TO     = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  C_ONE    = CNT_W'(1);
    localparam logic [GOOD_W-1:0] C_LOCKN  = GOOD_W'(LOCK_N);
    localparam logic [GOOD_W-1:0] C_LOCKM1 = GOOD_W'(LOCK_N - 1);
    localparam logic [GOOD_W-1:0] C_GONE   = GOOD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_TRACK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_div_q;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_hcnt;
    logic [GOOD_W-1:0] r_good;
    logic [GOOD_W-1:0] w_good_nxt;
    logic              r_tick;
    logic              r_meas_valid;
    logic [CNT_W-1:0]  r_period;
    logic [CNT_W-1:0]  r_high_time;
    logic              r_lock;
    logic              w_lock_nxt;
    logic              r_period_err;
    logic              r_stall;
    logic [15:0]       r_edge_count;
    logic              w_err_set;
    logic              w_stall_set;
    logic              w_rise;
    logic              w_measure;

    // A rise only counts while enabled; div_q keeps tracking while disabled
    // so re-enabling on a high level cannot look like a fresh rise.
    assign w_rise    = enable & div_in & ~r_div_q;
    assign w_measure = w_rise & (r_state != S_IDLE);

    // State register for the lock-tracking FSM.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, good-period run length, lock and error/stall set requests.
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_lock_nxt  = r_lock;
        w_err_set   = 1'b0;
        w_stall_set = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_good_nxt  = '0;
            w_lock_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // First rise only gives a reference point; nothing to measure yet.
                    if (w_rise) begin
                        w_state_nxt = S_ARMED;
                    end
                end
                default: begin
                    if (w_rise) begin
                        if (r_cnt == C_EXP) begin
                            if (r_good >= C_LOCKM1) begin
                                w_good_nxt  = C_LOCKN;
                                w_lock_nxt  = 1'b1;
                                w_state_nxt = S_LOCKED;
                            end else begin
                                w_good_nxt  = r_good + C_GONE;
                                w_state_nxt = (r_state == S_ARMED) ? S_TRACK : r_state;
                            end
                        end else begin
                            w_err_set   = 1'b1;
                            w_good_nxt  = '0;
                            w_lock_nxt  = 1'b0;
                            w_state_nxt = S_TRACK;
                        end
                    end else if (r_cnt == C_TO) begin
                        // Divider went quiet: drop back and wait for it to restart.
                        w_stall_set = 1'b1;
                        w_good_nxt  = '0;
                        w_lock_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            endcase
        end
    end

    // Edge history, period/high-time counters and the per-rise pulses.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_div_q      <= 1'b0;
            r_cnt        <= '0;
            r_hcnt       <= '0;
            r_tick       <= 1'b0;
            r_meas_valid <= 1'b0;
            r_edge_count <= '0;
        end else begin
            r_div_q <= div_in;
            if (!enable) begin
                r_cnt        <= '0;
                r_hcnt       <= '0;
                r_tick       <= 1'b0;
                r_meas_valid <= 1'b0;
            end else begin
                r_tick       <= w_rise;
                r_meas_valid <= w_measure;
                if (w_rise) begin
                    r_cnt  <= C_ONE;
                    r_hcnt <= C_ONE;
                    if (r_edge_count != 16'hFFFF) begin
                        r_edge_count <= r_edge_count + 16'd1;
                    end
                end else begin
                    if (r_cnt != C_TO) begin
                        r_cnt <= r_cnt + C_ONE;
                    end
                    if (div_in && (r_hcnt != C_TO)) begin
                        r_hcnt <= r_hcnt + C_ONE;
                    end
                end
            end
        end
    end

    // Capture the finished period's measurements on each measuring rise.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_period    <= '0;
            r_high_time <= '0;
        end else if (w_measure) begin
            r_period    <= r_cnt;
            r_high_time <= r_hcnt;
        end
    end

    // Good-run count, lock, and sticky flags where a new error beats err_clr.
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            r_good       <= '0;
            r_lock       <= 1'b0;
            r_period_err <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_good       <= w_good_nxt;
            r_lock       <= w_lock_nxt;
            r_period_err <= w_err_set   | (r_period_err & ~err_clr);
            r_stall      <= w_stall_set | (r_stall & ~err_clr);
        end
    end

    assign tick       = r_tick;
    assign meas_valid = r_meas_valid;
    assign period     = r_period;
    assign high_time  = r_high_time;
    assign lock       = r_lock;
    assign period_err = r_period_err;
    assign stall      = r_stall;
    assign edge_count = r_edge_count;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: a queue-based reference model records the
// div_in samples since the last rise and derives period, high time, lock
// and sticky flags from that history.
module tb_clk_div_monitor;

    localparam int EXP_PERIOD = 5;
    localparam int LOCK_N     = 4;
    localparam int TIMEOUT    = 64;
    localparam int CNT_W      = 8;
    localparam int VW         = 4 + 2 * CNT_W + 4 + 16 + 1;

    logic             clk_in = 1'b0;
    logic             rst;
    logic             div_in;
    logic             enable;
    logic             err_clr;
    logic             tick;
    logic             meas_valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             lock;
    logic             period_err;
    logic             stall;
    logic [15:0]      edge_count;
    logic [1:0]       dbg_state;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;

    // model state
    logic             m_prev;
    logic             m_hist[$];
    bit               m_seen;
    int               m_run;
    logic             m_tick, m_mv, m_lock, m_perr, m_stall;
    logic [CNT_W-1:0] m_period, m_high;
    logic [15:0]      m_ec;
    logic [VW-1:0]    exp_q[$];
    logic [VW-1:0]    got_vec;
    logic [VW-1:0]    chk_v;

    clk_div_monitor #(
        .EXP_PERIOD(EXP_PERIOD), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk_in(clk_in), .rst(rst), .div_in(div_in), .enable(enable),
        .err_clr(err_clr), .tick(tick), .meas_valid(meas_valid),
        .period(period), .high_time(high_time), .lock(lock),
        .period_err(period_err), .stall(stall), .edge_count(edge_count),
        .dbg_state(dbg_state)
    );

    assign got_vec = {tick, meas_valid, period, high_time, lock, period_err,
                      stall, 1'b0, edge_count, (dbg_state == 2'd0)};

    // clock
    always #5 clk_in = ~clk_in;

    // reference model: advance one clk_in edge from the sampled inputs
    task automatic model_step();
        logic rise;
        logic new_err;
        logic new_stall;
        int   ones;
        if (!rst) begin
            m_prev = 1'b0; m_hist.delete(); m_seen = 0; m_run = 0;
            m_tick = 0; m_mv = 0; m_lock = 0; m_perr = 0; m_stall = 0;
            m_period = '0; m_high = '0; m_ec = '0;
        end else begin
            rise      = enable && div_in && !m_prev;
            m_prev    = div_in;
            new_err   = 1'b0;
            new_stall = 1'b0;
            if (!enable) begin
                m_tick = 0; m_mv = 0; m_lock = 0; m_run = 0; m_seen = 0;
                m_hist.delete();
            end else begin
                m_tick = rise;
                m_mv   = 1'b0;
                if (rise) begin
                    if (m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
                    if (m_seen) begin
                        ones = 0;
                        foreach (m_hist[i]) ones += int'(m_hist[i]);
                        m_mv     = 1'b1;
                        m_period = CNT_W'(m_hist.size());
                        m_high   = CNT_W'(ones);
                        if (m_hist.size() == EXP_PERIOD) begin
                            m_run++;
                            if (m_run >= LOCK_N) m_lock = 1'b1;
                        end else begin
                            new_err = 1'b1; m_run = 0; m_lock = 1'b0;
                        end
                    end
                    m_seen = 1;
                    m_hist.delete();
                    m_hist.push_back(1'b1);
                end else if (m_seen) begin
                    if (m_hist.size() >= TIMEOUT) begin
                        new_stall = 1'b1; m_lock = 1'b0; m_run = 0; m_seen = 0;
                        m_hist.delete();
                    end else begin
                        m_hist.push_back(div_in);
                    end
                end
            end
            m_perr  = new_err   ? 1'b1 : (err_clr ? 1'b0 : m_perr);
            m_stall = new_stall ? 1'b1 : (err_clr ? 1'b0 : m_stall);
        end
        exp_q.push_back({m_tick, m_mv, m_period, m_high, m_lock, m_perr,
                         m_stall, 1'b0, m_ec, !m_seen});
    endtask

    // driver: apply div_in for one clock, advance the model, settle past the edge
    task automatic cyc(input logic d);
        div_in = d;
        @(posedge clk_in);
        model_step();
        cyc_n++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b1; err_clr = 1'b0;
        cyc(1'b0);
        chk_v = exp_q.pop_front();
        n_total++;
        if (got_vec !== chk_v) begin
            n_bad++; $display("FAIL reset_vec got=%h exp=%h", got_vec, chk_v);
        end
        n_total++;
        if ({tick, meas_valid, period, high_time, lock, period_err, stall, edge_count} !== '0
            || dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_zero tick=%b mv=%b per=%0d hi=%0d lock=%b perr=%b stall=%b ec=%0d st=%0d exp all 0",
                     tick, meas_valid, period, high_time, lock, period_err, stall, edge_count, dbg_state);
        end
        rst = 1'b1;
        cyc(1'b0);
        chk_v = exp_q.pop_front();
        n_total++;
        if (got_vec !== chk_v) begin
            n_bad++; $display("FAIL reset_idle got=%h exp=%h", got_vec, chk_v);
        end
    endtask

    task automatic test_lock();
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 5; k++) begin
                cyc(k < 3);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL lock_seq cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
                if (k == 0) begin
                    n_total++;
                    if (tick !== 1'b1 || meas_valid !== (j >= 1) || lock !== (j >= 4)
                        || period_err !== 1'b0
                        || (j >= 1 && (period !== 8'd5 || high_time !== 8'd3))) begin
                        n_bad++;
                        $display("FAIL lock_rise j=%0d tick=%b mv=%b per=%0d hi=%0d lock=%b perr=%b exp tick=1 mv=%0d per=5 hi=3 lock=%0d perr=0",
                                 j, tick, meas_valid, period, high_time, lock, period_err, j >= 1, j >= 4);
                    end
                end
            end
        end
    endtask

    task automatic test_stretch();
        int p;
        for (int j = 0; j < 6; j++) begin
            p = (j == 0) ? 6 : 5;
            for (int k = 0; k < p; k++) begin
                cyc(k < 3);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL stretch_seq cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
                if (k == 0 && j == 1) begin
                    n_total++;
                    if (meas_valid !== 1'b1 || period !== 8'd6 || period_err !== 1'b1 || lock !== 1'b0) begin
                        n_bad++;
                        $display("FAIL stretch_err mv=%b per=%0d perr=%b lock=%b exp mv=1 per=6 perr=1 lock=0",
                                 meas_valid, period, period_err, lock);
                    end
                end
                if (k == 0 && j >= 2) begin
                    n_total++;
                    if (lock !== (j == 5) || period_err !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stretch_relock j=%0d lock=%b perr=%b exp lock=%0d perr=1",
                                 j, lock, period_err, j == 5);
                    end
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int k = 0; k < 70; k++) begin
            cyc(1'b0);
            chk_v = exp_q.pop_front();
            n_total++;
            if (got_vec !== chk_v) begin
                n_bad++; $display("FAIL stall_seq cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
            end
        end
        n_total++;
        if (stall !== 1'b1 || lock !== 1'b0 || dbg_state !== 2'd0) begin
            n_bad++;
            $display("FAIL stall_flag stall=%b lock=%b st=%0d exp stall=1 lock=0 st=0", stall, lock, dbg_state);
        end
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 5; k++) begin
                err_clr = (j == 5 && k == 4);
                cyc(k < 3);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL stall_relock_seq cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
                if (k == 0 && j <= 4) begin
                    n_total++;
                    if (lock !== (j == 4) || stall !== 1'b1) begin
                        n_bad++;
                        $display("FAIL stall_relock j=%0d lock=%b stall=%b exp lock=%0d stall=1", j, lock, stall, j == 4);
                    end
                end
            end
        end
        err_clr = 1'b0;
        n_total++;
        if (stall !== 1'b0 || period_err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clr_quiet stall=%b perr=%b exp 0 0", stall, period_err);
        end
    endtask

    task automatic test_err_race();
        int p;
        int h;
        for (int j = 0; j < 3; j++) begin
            p = (j == 0) ? 4 : 5;
            h = (j == 0) ? 2 : 3;
            for (int k = 0; k < p; k++) begin
                err_clr = (j == 1 && (k == 0 || k == 3));
                cyc(k < h);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL race_seq cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
                if (j == 1 && k == 0) begin
                    n_total++;
                    if (period_err !== 1'b1 || period !== 8'd4) begin
                        n_bad++;
                        $display("FAIL race_err_wins perr=%b per=%0d exp perr=1 per=4", period_err, period);
                    end
                end
                if (j == 1 && k == 3) begin
                    n_total++;
                    if (period_err !== 1'b0) begin
                        n_bad++; $display("FAIL race_clear perr=%b exp 0", period_err);
                    end
                end
            end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 6; j++) begin
            for (int k = 0; k < 5; k++) begin
                cyc(k < 3);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL rmid_pre cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
            end
        end
        n_total++;
        if (lock !== 1'b1) begin
            n_bad++; $display("FAIL rmid_locked lock=%b exp 1", lock);
        end
        rst = 1'b0;
        cyc(1'b1);
        chk_v = exp_q.pop_front();
        rst = 1'b1;
        n_total++;
        if ({tick, meas_valid, period, high_time, lock, period_err, stall, edge_count} !== '0
            || got_vec !== chk_v) begin
            n_bad++;
            $display("FAIL rmid_zero got=%h exp=%h", got_vec, chk_v);
        end
        cyc(1'b0); chk_v = exp_q.pop_front();
        cyc(1'b0); chk_v = exp_q.pop_front();
        for (int j = 0; j < 5; j++) begin
            for (int k = 0; k < 5; k++) begin
                cyc(k < 3);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL rmid_post cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
                if (k == 0) begin
                    n_total++;
                    if (lock !== (j == 4) || meas_valid !== (j >= 1) || edge_count !== 16'(j + 1)) begin
                        n_bad++;
                        $display("FAIL rmid_relock j=%0d lock=%b mv=%b ec=%0d exp lock=%0d mv=%0d ec=%0d",
                                 j, lock, meas_valid, edge_count, j == 4, j >= 1, j + 1);
                    end
                end
            end
        end
    endtask

    task automatic test_enable();
        logic [15:0] ec_before;
        cyc(1'b1); chk_v = exp_q.pop_front();
        cyc(1'b1); chk_v = exp_q.pop_front();
        ec_before = m_ec;
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'b1);
            chk_v = exp_q.pop_front();
            n_total++;
            if (got_vec !== chk_v) begin
                n_bad++; $display("FAIL en_off cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
            end
        end
        enable = 1'b1;
        cyc(1'b1);
        chk_v = exp_q.pop_front();
        n_total++;
        if (tick !== 1'b0 || edge_count !== ec_before || lock !== 1'b0 || got_vec !== chk_v) begin
            n_bad++;
            $display("FAIL en_back tick=%b ec=%0d lock=%b exp tick=0 ec=%0d lock=0", tick, edge_count, lock, ec_before);
        end
        cyc(1'b1); chk_v = exp_q.pop_front();
        cyc(1'b0); chk_v = exp_q.pop_front();
        cyc(1'b0); chk_v = exp_q.pop_front();
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 5; k++) begin
                cyc(k < 3);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL en_rearm_seq cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
                if (k == 0) begin
                    n_total++;
                    if (tick !== 1'b1 || meas_valid !== (j == 1) || edge_count !== ec_before + 16'(j + 1)) begin
                        n_bad++;
                        $display("FAIL en_rearm j=%0d tick=%b mv=%b ec=%0d exp tick=1 mv=%0d ec=%0d",
                                 j, tick, meas_valid, edge_count, j == 1, ec_before + 16'(j + 1));
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        int p;
        int h;
        int gap;
        for (int j = 0; j < 60; j++) begin
            p = ($urandom_range(0, 2) != 0) ? 5 : int'($urandom_range(2, 9));
            h = int'($urandom_range(1, p - 1));
            gap = ($urandom_range(0, 11) == 0) ? int'($urandom_range(60, 70)) : 0;
            for (int k = 0; k < p + gap; k++) begin
                err_clr = ($urandom_range(0, 15) == 0);
                enable  = !(j % 9 == 4 && k >= 1 && k <= 3);
                cyc(k < h);
                chk_v = exp_q.pop_front();
                n_total++;
                if (got_vec !== chk_v) begin
                    n_bad++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc_n, got_vec, chk_v);
                end
            end
        end
        err_clr = 1'b0;
        enable  = 1'b1;
    endtask

    initial begin
        rst = 1'b0; div_in = 1'b0; enable = 1'b1; err_clr = 1'b0;
        test_reset();
        test_lock();
        test_stretch();
        test_stall();
        test_err_race();
        test_reset_mid();
        test_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
